// File: rtl/phoenix_local_tx.sv
// phoenix_local_tx
//   Transmit end of the credit-based link between a processing element and
//   the LOCAL input port of its Phoenix router. Payload flits written by the
//   core are queued in a small FIFO. On request, a packet is serialised as
//   the header (target), the size (length), then `length` payload flits.
//
// Ports
//   clock      in   system clock, rising-edge
//   reset      in   asynchronous, active-low reset
//   req        in   packet send request (honoured only while not busy)
//   target     in   header flit, latched on request acceptance
//   length     in   payload flit count, latched on request acceptance
//   busy       out  packet in progress
//   done       out  one-cycle pulse after the final transfer of a packet
//   wr_en      in   payload FIFO write strobe
//   wr_data    in   payload flit
//   full       out  payload FIFO full
//   tx         out  flit valid toward the router
//   data_out   out  flit toward the router (zero when tx is low)
//   credit_i   in   router has space; transfer on edge with tx & credit_i
//   clock_tx   out  forwarded link clock
module phoenix_local_tx #(
    parameter int unsigned TAM_FLIT   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req,
    input  logic [TAM_FLIT-1:0] target,
    input  logic [TAM_FLIT-1:0] length,
    output logic                busy,
    output logic                done,
    input  logic                wr_en,
    input  logic [TAM_FLIT-1:0] wr_data,
    output logic                full,
    output logic                tx,
    output logic [TAM_FLIT-1:0] data_out,
    input  logic                credit_i,
    output logic                clock_tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_SIZE,
        S_PAYLOAD
    } state_e;

    state_e                state_q, state_d;
    logic [TAM_FLIT-1:0]   tgt_q, tgt_d;
    logic [TAM_FLIT-1:0]   len_q, len_d;
    logic [TAM_FLIT-1:0]   rem_q, rem_d;
    logic                  done_q, done_d;
    logic                  tx_q, tx_d;
    logic [TAM_FLIT-1:0]   data_q, data_d;

    logic [TAM_FLIT-1:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;

    logic                  full_w;
    logic                  empty_d;
    logic                  push;
    logic                  pop;
    logic                  xfer;
    logic [TAM_FLIT-1:0]   head_d;

    // Full when the index bits match but the wrap bits differ.
    assign full_w = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    always_comb begin
        xfer   = tx_q && credit_i;
        push   = wr_en && !full_w;
        pop    = xfer && (state_q == S_PAYLOAD);
        wptr_d = wptr_q + {{AW{1'b0}}, push};
        rptr_d = rptr_q + {{AW{1'b0}}, pop};

        state_d = state_q;
        tgt_d   = tgt_q;
        len_d   = len_q;
        rem_d   = rem_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_HEADER;
                    tgt_d   = target;
                    len_d   = length;
                    rem_d   = length;
                end
            end
            S_HEADER: begin
                if (xfer) state_d = S_SIZE;
            end
            S_SIZE: begin
                if (xfer) begin
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (pop) begin
                    rem_d = rem_q - TAM_FLIT'(1);
                    if (rem_q == TAM_FLIT'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx/data_out are registered, so they are computed from the
        // post-edge FSM state and FIFO pointers. When the write lands in
        // the slot that becomes the head, the head is the incoming flit.
        empty_d = (wptr_d == rptr_d);
        head_d  = (push && (rptr_d == wptr_q)) ? wr_data : mem_q[rptr_d[AW-1:0]];

        tx_d   = 1'b0;
        data_d = '0;
        case (state_d)
            S_HEADER: begin
                tx_d   = 1'b1;
                data_d = tgt_d;
            end
            S_SIZE: begin
                tx_d   = 1'b1;
                data_d = len_d;
            end
            S_PAYLOAD: begin
                if (!empty_d) begin
                    tx_d   = 1'b1;
                    data_d = head_d;
                end
            end
            default: begin
                tx_d   = 1'b0;
                data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            tx_q    <= 1'b0;
            data_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
            data_q  <= data_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wr_data;
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign full     = full_w;
    assign tx       = tx_q;
    assign data_out = data_q;
    assign clock_tx = clock;

endmodule

// File: tb/tb_phoenix_local_tx.sv
// tb_phoenix_local_tx
//   Directed and random stimulus for phoenix_local_tx, checked cycle by cycle
//   against a packet-level reference model (flit counts and a flit queue).
module tb_phoenix_local_tx;

    localparam int W = 16;
    localparam int D = 4;

    logic          clock;
    logic          reset;
    logic          req;
    logic [W-1:0]  target;
    logic [W-1:0]  length;
    logic          busy;
    logic          done;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          full;
    logic          tx;
    logic [W-1:0]  data_out;
    logic          credit_i;
    logic          clock_tx;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: flits still owed for the current packet (header and
    // size included), latched header fields, queued payload, done pulse.
    int            fl;
    logic [W-1:0]  m_tgt;
    logic [W-1:0]  m_len;
    logic [W-1:0]  mq[$];
    bit            m_done;

    phoenix_local_tx #(.TAM_FLIT(W), .FIFO_DEPTH(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .target   (target),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .tx       (tx),
        .data_out (data_out),
        .credit_i (credit_i),
        .clock_tx (clock_tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int pos_f();
        return int'(m_len) + 2 - fl;
    endfunction

    function automatic bit exp_tx();
        return (fl > 0) && ((pos_f() < 2) || (mq.size() > 0));
    endfunction

    function automatic logic [W-1:0] exp_data();
        if (!exp_tx()) return '0;
        if (pos_f() == 0) return m_tgt;
        if (pos_f() == 1) return m_len;
        return mq[0];
    endfunction

    task automatic model_reset();
        fl     = 0;
        m_tgt  = '0;
        m_len  = '0;
        m_done = 1'b0;
        mq.delete();
    endtask

    task automatic model_step(input bit r, input logic [W-1:0] tg, input logic [W-1:0] ln,
                              input bit w, input logic [W-1:0] wd, input bit cr);
        bit xfer;
        bit full_e;
        bit busy_e;
        int p;
        xfer   = exp_tx() && cr;
        p      = pos_f();
        full_e = (mq.size() == D);
        busy_e = (fl > 0);
        m_done = xfer && (fl == 1);
        if (xfer && p >= 2) void'(mq.pop_front());
        if (w && !full_e) mq.push_back(wd);
        if (xfer) fl--;
        else if (!busy_e && r) begin
            fl    = int'(ln) + 2;
            m_tgt = tg;
            m_len = ln;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("tx",       32'(tx),       32'(exp_tx()));
        chk("data_out", 32'(data_out), 32'(exp_data()));
        chk("busy",     32'(busy),     32'(fl > 0));
        chk("done",     32'(done),     32'(m_done));
        chk("full",     32'(full),     32'(mq.size() == D));
    endtask

    task automatic check_reset_state();
        chk("rst_tx",       32'(tx),       32'h0);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_busy",     32'(busy),     32'h0);
        chk("rst_done",     32'(done),     32'h0);
        chk("rst_full",     32'(full),     32'h0);
    endtask

    // Drive one cycle of inputs (called just after a falling edge), advance
    // the model at the rising edge, compare on the next falling edge.
    task automatic cyc(input bit r, input logic [W-1:0] tg, input logic [W-1:0] ln,
                       input bit w, input logic [W-1:0] wd, input bit cr);
        req      = r;
        target   = tg;
        length   = ln;
        wr_en    = w;
        wr_data  = wd;
        credit_i = cr;
        @(posedge clock);
        model_step(r, tg, ln, w, wd, cr);
        @(negedge clock);
        check_all();
    endtask

    task automatic idle(input int n, input bit cr);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, cr);
    endtask

    task automatic wr(input logic [W-1:0] v, input bit cr);
        cyc(1'b0, '0, '0, 1'b1, v, cr);
    endtask

    initial begin
        reset    = 1'b0;
        req      = 1'b0;
        target   = '0;
        length   = '0;
        wr_en    = 1'b0;
        wr_data  = '0;
        credit_i = 1'b0;
        model_reset();
        #1;
        check_reset_state();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        check_all();
        chk("clock_tx", 32'(clock_tx), 32'(clock));

        // Basic packet: preload A1..A3, send target 0x0011, length 3.
        wr(16'h00A1, 1'b1);
        wr(16'h00A2, 1'b1);
        wr(16'h00A3, 1'b1);
        cyc(1'b1, 16'h0011, 16'd3, 1'b0, '0, 1'b1);
        chk("basic_hdr", 32'(data_out), 32'h0011);
        idle(1, 1'b1);
        chk("basic_size", 32'(data_out), 32'h0003);
        idle(1, 1'b1);
        chk("basic_p0", 32'(data_out), 32'h00A1);
        idle(3, 1'b1);
        chk("basic_done", 32'(done), 32'h1);
        chk("basic_busy", 32'(busy), 32'h0);
        idle(1, 1'b1);

        // Backpressure during the size flit.
        wr(16'h00B1, 1'b1);
        wr(16'h00B2, 1'b1);
        wr(16'h00B3, 1'b1);
        cyc(1'b1, 16'h0011, 16'd3, 1'b0, '0, 1'b1);
        idle(1, 1'b1);
        idle(3, 1'b0);
        chk("bp_hold", 32'(data_out), 32'h0003);
        idle(6, 1'b1);

        // Zero length with one flit queued: the flit stays queued.
        wr(16'h00C1, 1'b1);
        cyc(1'b1, 16'h0022, 16'd0, 1'b0, '0, 1'b1);
        idle(4, 1'b1);
        cyc(1'b1, 16'h0023, 16'd1, 1'b0, '0, 1'b1);
        idle(4, 1'b1);

        // Starvation then full: length 6, empty FIFO.
        cyc(1'b1, 16'h0033, 16'd6, 1'b0, '0, 1'b1);
        idle(5, 1'b1);
        chk("starve_tx", 32'(tx), 32'h0);
        wr(16'h00D1, 1'b0);
        wr(16'h00D2, 1'b0);
        wr(16'h00D3, 1'b0);
        wr(16'h00D4, 1'b0);
        chk("full_set", 32'(full), 32'h1);
        wr(16'h00DF, 1'b0);
        idle(5, 1'b1);
        wr(16'h00D5, 1'b1);
        wr(16'h00D6, 1'b1);
        idle(4, 1'b1);

        // Back-to-back with req held high throughout.
        wr(16'h00E1, 1'b1);
        wr(16'h00E2, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b1, 16'h0044, 16'd1, 1'b0, '0, 1'b1);
        idle(4, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom_range(0, 5)),
                1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0));
        end
        idle(40, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0055, 16'd0, 1'b0, '0, 1'b1);
        idle(4, 1'b1);

        // Reset mid-packet with two flits still queued.
        wr(16'h00F1, 1'b1);
        wr(16'h00F2, 1'b1);
        wr(16'h00F3, 1'b1);
        cyc(1'b1, 16'h0066, 16'd3, 1'b0, '0, 1'b1);
        idle(3, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_state();
        @(negedge clock);
        reset = 1'b1;
        check_all();
        cyc(1'b1, 16'h0077, 16'd1, 1'b0, '0, 1'b1);
        idle(4, 1'b1);
        wr(16'h0091, 1'b1);
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
